// File: rtl/rom_loader_if.sv
// Byte-stream input and inst_mem write port of the ROM loader.
// The loader takes the slave side; the byte source / memory model takes the master side.
interface rom_loader_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;

  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/rom_loader.sv
// Loads framed byte stream (A5, LEN_L, LEN_H, 4*N data, XOR checksum) into inst_mem
// as little-endian words, holding the core in reset while a frame is in flight.
//   state  | meaning
//   IDLE   | waiting for sync byte 0xA5, other bytes dropped
//   LEN0   | expecting word count low byte
//   LEN1   | expecting word count high byte, range check
//   DATA   | collecting the four bytes of a word
//   WR     | one-cycle write strobe, no byte accepted
//   CHK    | expecting checksum byte
module rom_loader #(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  rom_loader_if.slave  bus,
  output logic         hold_cpu_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [31:0] MAX_N   = 32'd1 << ADDR_W;

  logic [2:0]    state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [23:0]   word_q, word_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic        accept;
  logic [15:0] len_in;

  assign accept = bus.rx_valid_i && bus.rx_ready_o;
  assign len_in = {bus.rx_data_i, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    chk_d      = chk_q;
    word_d     = word_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (state_q == S_IDLE || accept) tmo_d = '0;
    else                             tmo_d = tmo_q + TW'(1);

    case (state_q)
      S_IDLE: if (accept && bus.rx_data_i == 8'hA5) begin
        state_d = S_LEN0;
        err_d   = 1'b0;
      end
      S_LEN0: if (accept) begin
        len_d[7:0] = bus.rx_data_i;
        state_d    = S_LEN1;
      end
      S_LEN1: if (accept) begin
        len_d      = len_in;
        word_idx_d = '0;
        byte_idx_d = '0;
        chk_d      = '0;
        if ({16'd0, len_in} > MAX_N) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (len_in == 16'd0) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        chk_d      = chk_q ^ bus.rx_data_i;
        byte_idx_d = byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0: word_d[7:0]   = bus.rx_data_i;
          2'd1: word_d[15:8]  = bus.rx_data_i;
          2'd2: word_d[23:16] = bus.rx_data_i;
          default: begin
            data_d  = {bus.rx_data_i, word_q};
            addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            state_d = S_WR;
          end
        endcase
      end
      S_WR: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_q == len_q - 16'd1) ? S_CHK : S_DATA;
      end
      S_CHK: if (accept) begin
        state_d = S_IDLE;
        if (bus.rx_data_i == chk_q) done_d = 1'b1;
        else                        err_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // An accepted byte always beats the timeout.
    if (state_q != S_IDLE && !accept && tmo_q == TO_LAST) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      chk_q      <= '0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      chk_q      <= chk_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.rx_ready_o = (state_q != S_WR);
  assign bus.mem_we_o   = (state_q == S_WR);
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  // Every non-IDLE state lies between LEN0 and CHK, so hold and busy coincide.
  assign busy_o     = (state_q != S_IDLE);
  assign hold_cpu_o = busy_o;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus random frames checked
// against a frame-level model of expected writes, checksum and done/err outcome.
module tb_rom_loader;
  localparam int          ADDR_W  = 12;
  localparam logic [31:0] BASE    = 32'h0;
  localparam int          TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold_cpu, busy, done, err;

  rom_loader_if bus ();

  rom_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .hold_cpu_o (hold_cpu),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [63:0] got[$];
  logic [31:0] fw[$];

  always @(negedge clk) begin
    if (bus.mem_we_o) got.push_back({bus.mem_addr_o, bus.mem_data_o});
    if (done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    while (!bus.rx_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("ready_wait", 64'(w), 64'd0);
    @(posedge clk);
    #1 bus.rx_valid_i = 1'b0;
  endtask

  // Frame-level model: writes at BASE+4*i of fw[i], checksum = XOR of all data bytes.
  task automatic run_frame(input bit bad, input int maxgap);
    logic [7:0]  chk;
    logic [31:0] w;
    logic [63:0] exp_w[$];
    int n;
    n = fw.size();
    chk = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      exp_w.push_back({BASE + 32'(4 * i), w});
      for (int b = 0; b < 4; b++) chk = chk ^ w[8*b +: 8];
    end
    got.delete();
    done_cnt = 0;
    send_byte(8'hA5);
    check("hold_after_sync", 64'(hold_cpu), 64'd1);
    check("err_clr_on_sync", 64'(err), 64'd0);
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        repeat ($urandom_range(0, maxgap)) @(posedge clk);
      end
    end
    send_byte(bad ? (chk ^ 8'h5C) : chk);
    check("done_first_idle", 64'(done), 64'(!bad));
    check("err_first_idle", 64'(err), 64'(bad));
    check("hold_drop", 64'(hold_cpu), 64'd0);
    check("busy_drop", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'(!bad));
    check("nwrites", 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++) check("write", got[i], exp_w[i]);
    if (n > 0) check("addr_data_hold", {bus.mem_addr_o, bus.mem_data_o}, exp_w[n-1]);
  endtask

  initial begin
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.rx_ready_o), 64'd1);
    check("rst_we", 64'(bus.mem_we_o), 64'd0);
    check("rst_addr", 64'(bus.mem_addr_o), 64'(BASE));
    check("rst_data", 64'(bus.mem_data_o), 64'd0);
    check("rst_flags", {60'd0, hold_cpu, busy, done, err}, 64'd0);
    @(negedge clk) rst = 1'b0;

    // Directed good frame, then the same frame with a bad checksum.
    fw = '{32'h0000_0013, 32'h0010_0093};
    run_frame(1'b0, 0);
    run_frame(1'b1, 0);
    send_byte(8'h00);
    check("err_sticky", 64'(err), 64'd1);
    send_byte(8'hA5);
    check("err_clr_sync", 64'(err), 64'd0);
    check("busy_len0", 64'(busy), 64'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("empty_done", 64'(done), 64'd1);

    // Leading junk is dropped without raising hold.
    send_byte(8'h00);
    check("junk_hold0", 64'(hold_cpu), 64'd0);
    send_byte(8'hFF);
    check("junk_hold1", 64'(hold_cpu), 64'd0);
    send_byte(8'h5A);
    check("junk_busy", 64'(busy), 64'd0);
    fw = '{32'hDEAD_BEEF};
    run_frame(1'b0, 1);

    // Zero-length frame, then an oversize length.
    fw.delete();
    run_frame(1'b0, 0);
    got.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    check("oversize_err", 64'(err), 64'd1);
    check("oversize_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 check("oversize_nowr", 64'(got.size()), 64'd0);
    fw = '{32'hCAFE_0001, 32'h1234_5678, 32'h0BAD_F00D, 32'h00A5_A500};
    fw.push_back(32'hFFFF_FFFF);
    run_frame(1'b0, 0);

    // Timeout after the second data byte.
    got.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1 check("tmo_not_yet", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("tmo_busy", 64'(busy), 64'd0);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_nowr", 64'(got.size()), 64'd0);
    fw = '{$urandom, $urandom};
    run_frame(1'b0, 3);

    // Reset mid-frame during word 1 of 3.
    fw = '{$urandom, $urandom, $urandom};
    got.delete();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    for (int b = 0; b < 4; b++) send_byte(8'(fw[0] >> (8 * b)));
    send_byte(8'(fw[1]));
    send_byte(8'(fw[1] >> 8));
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_ready", 64'(bus.rx_ready_o), 64'd1);
    check("mrst_we", 64'(bus.mem_we_o), 64'd0);
    check("mrst_addr", 64'(bus.mem_addr_o), 64'(BASE));
    check("mrst_data", 64'(bus.mem_data_o), 64'd0);
    check("mrst_flags", {60'd0, hold_cpu, busy, done, err}, 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mrst_nwrites", 64'(got.size()), 64'd1);
    if (got.size() > 0) check("mrst_word0", got[0], {BASE, fw[0]});

    // Random frames with random gaps below the timeout.
    for (int f = 0; f < 8; f++) begin
      fw.delete();
      for (int i = 0, n = $urandom_range(1, 5); i < n; i++) fw.push_back($urandom);
      run_frame($urandom_range(0, 3) == 0, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
